// File: rtl/sensor_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sensor_mode_ctrl
// Description : Night-mode traffic controller. Main street rests on green.
//               Latched side-street requests are served round-robin through
//               a yellow / all-red / green / yellow / all-red sequence timed
//               by a one-second tick prescaler, with a pedestrian walk
//               countdown shown during side green.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_mode_ctrl #(
  parameter int N_SIDE     = 2,
  parameter int TICK_DIV   = 50_000_000,
  parameter int MIN_GREEN  = 10,
  parameter int SIDE_GREEN = 8,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 1,
  parameter int WALK_TIME  = 9
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  enable_sensor_mode,
  input  logic [N_SIDE-1:0]     sensor,
  output logic [2:0]            main_light,
  output logic [3*N_SIDE-1:0]   side_light,
  output logic                  walk_active,
  output logic [3:0]            walk_digit,
  output logic [N_SIDE-1:0]     pending,
  output logic [2:0]            phase
);

  // Widths sized from the longest duration, the prescaler period and N_SIDE
  localparam int MAX_A   = (MIN_GREEN > SIDE_GREEN) ? MIN_GREEN : SIDE_GREEN;
  localparam int MAX_B   = (YELLOW > ALL_RED) ? YELLOW : ALL_RED;
  localparam int MAX_DUR = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW      = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
  localparam int PW      = $clog2(TICK_DIV);
  localparam int SW      = (N_SIDE > 1) ? $clog2(N_SIDE) : 1;

  localparam logic [PW-1:0] PRESC_MAX     = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] MIN_GREEN_LD  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] SIDE_GREEN_LD = TW'(SIDE_GREEN - 1);
  localparam logic [TW-1:0] YELLOW_LD     = TW'(YELLOW - 1);
  localparam logic [TW-1:0] ALL_RED_LD    = TW'(ALL_RED - 1);
  localparam logic [3:0]    WALK_START    = 4'(WALK_TIME);

  // One-hot light encodings {R,Y,G}
  localparam logic [2:0] LIGHT_R = 3'b100;
  localparam logic [2:0] LIGHT_Y = 3'b010;
  localparam logic [2:0] LIGHT_G = 3'b001;

  typedef enum logic [2:0] {
    ST_MAIN_GREEN  = 3'd0,
    ST_MAIN_YELLOW = 3'd1,
    ST_ALL_RED_A   = 3'd2,
    ST_SIDE_GREEN  = 3'd3,
    ST_SIDE_YELLOW = 3'd4,
    ST_ALL_RED_B   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic                  min_done_q, min_done_d;
  logic [N_SIDE-1:0]     pending_q, pending_d;
  logic [SW-1:0]         served_q, served_d;
  logic [SW-1:0]         last_served_q, last_served_d;
  logic [2:0]            main_light_q, main_light_d;
  logic [3*N_SIDE-1:0]   side_light_q, side_light_d;
  logic                  walk_active_q, walk_active_d;
  logic [3:0]            walk_digit_q, walk_digit_d;

  logic                  tick;
  logic                  expire;
  logic [SW-1:0]         rr_pick;
  logic                  rr_found;
  int                    rr_idx;

  assign tick = (presc_q == PRESC_MAX);

  // Round-robin pick: first pending approach after last_served, wrapping
  always_comb begin
    rr_pick  = last_served_q;
    rr_found = 1'b0;
    rr_idx   = 0;
    for (int i = 0; i < N_SIDE; i++) begin
      rr_idx = int'(last_served_q) + 1 + i;
      if (rr_idx >= N_SIDE) rr_idx = rr_idx - N_SIDE;
      for (int k = 0; k < N_SIDE; k++) begin
        if (!rr_found && (k == rr_idx) && pending_q[k]) begin
          rr_pick  = SW'(k);
          rr_found = 1'b1;
        end
      end
    end
  end

  // Next state, timers, request latches and registered-output values
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    presc_d       = presc_q;
    min_done_d    = min_done_q;
    pending_d     = pending_q;
    served_d      = served_q;
    last_served_d = last_served_q;
    main_light_d  = main_light_q;
    side_light_d  = side_light_q;
    walk_active_d = walk_active_q;
    walk_digit_d  = walk_digit_q;
    expire        = 1'b0;

    // With the block disabled every register simply holds
    if (enable_sensor_mode) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      expire  = tick && (timer_q == '0);
      if (tick && (timer_q != '0)) timer_d = timer_q - 1'b1;

      case (state_q)
        ST_MAIN_GREEN: begin
          if (expire) min_done_d = 1'b1;
          // The expiring tick itself already counts as minimum green done
          if ((min_done_q || expire) && (pending_q != '0)) begin
            state_d  = ST_MAIN_YELLOW;
            timer_d  = YELLOW_LD;
            served_d = rr_pick;
          end
        end
        ST_MAIN_YELLOW: begin
          if (expire) begin
            state_d = ST_ALL_RED_A;
            timer_d = ALL_RED_LD;
          end
        end
        ST_ALL_RED_A: begin
          if (expire) begin
            state_d = ST_SIDE_GREEN;
            timer_d = SIDE_GREEN_LD;
          end
        end
        ST_SIDE_GREEN: begin
          if (expire) begin
            state_d = ST_SIDE_YELLOW;
            timer_d = YELLOW_LD;
          end
        end
        ST_SIDE_YELLOW: begin
          if (expire) begin
            state_d       = ST_ALL_RED_B;
            timer_d       = ALL_RED_LD;
            last_served_d = served_q;
          end
        end
        ST_ALL_RED_B: begin
          if (expire) begin
            state_d    = ST_MAIN_GREEN;
            timer_d    = MIN_GREEN_LD;
            min_done_d = 1'b0;
          end
        end
        default: begin
          state_d    = ST_MAIN_GREEN;
          timer_d    = MIN_GREEN_LD;
          min_done_d = 1'b0;
        end
      endcase

      // Every state gets a full tick period for its first tick
      if (state_d != state_q) presc_d = '0;

      // Served request clears on side-green entry; a new sensor hit wins
      if ((state_d == ST_SIDE_GREEN) && (state_q != ST_SIDE_GREEN)) begin
        for (int k = 0; k < N_SIDE; k++) begin
          if (SW'(k) == served_q) pending_d[k] = 1'b0;
        end
      end
      pending_d = pending_d | sensor;

      // Lights follow the next state so they change with the phase
      if (state_d == ST_MAIN_GREEN)       main_light_d = LIGHT_G;
      else if (state_d == ST_MAIN_YELLOW) main_light_d = LIGHT_Y;
      else                                main_light_d = LIGHT_R;

      for (int k = 0; k < N_SIDE; k++) begin
        side_light_d[3*k +: 3] = LIGHT_R;
        if (SW'(k) == served_d) begin
          if (state_d == ST_SIDE_GREEN)       side_light_d[3*k +: 3] = LIGHT_G;
          else if (state_d == ST_SIDE_YELLOW) side_light_d[3*k +: 3] = LIGHT_Y;
        end
      end

      // Walk countdown: load on green entry, count down per tick, floor at 0
      walk_active_d = (state_d == ST_SIDE_GREEN);
      if (state_d != ST_SIDE_GREEN)
        walk_digit_d = 4'd0;
      else if (state_q != ST_SIDE_GREEN)
        walk_digit_d = WALK_START;
      else if (tick && (walk_digit_q != 4'd0))
        walk_digit_d = walk_digit_q - 4'd1;
    end
  end

  // Register bank for controller state and all outputs
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_MAIN_GREEN;
      timer_q       <= MIN_GREEN_LD;
      presc_q       <= '0;
      min_done_q    <= 1'b0;
      pending_q     <= '0;
      served_q      <= '0;
      last_served_q <= SW'(N_SIDE - 1);
      main_light_q  <= LIGHT_G;
      side_light_q  <= {N_SIDE{LIGHT_R}};
      walk_active_q <= 1'b0;
      walk_digit_q  <= 4'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      presc_q       <= presc_d;
      min_done_q    <= min_done_d;
      pending_q     <= pending_d;
      served_q      <= served_d;
      last_served_q <= last_served_d;
      main_light_q  <= main_light_d;
      side_light_q  <= side_light_d;
      walk_active_q <= walk_active_d;
      walk_digit_q  <= walk_digit_d;
    end
  end

  assign main_light  = main_light_q;
  assign side_light  = side_light_q;
  assign walk_active = walk_active_q;
  assign walk_digit  = walk_digit_q;
  assign pending     = pending_q;
  assign phase       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_mode_ctrl
// Description : Scoreboard bench for sensor_mode_ctrl. Stimulus queues the
//               expected output changes (value plus how long the previous
//               value lasted); a negedge monitor pops and compares on every
//               output change.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_mode_ctrl;

  localparam int NS = 3;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [8:0] ALL_R = {R, R, R};
  localparam logic [19:0] RST_VEC = {3'd0, G, ALL_R, 1'b0, 4'd0};

  logic            CLOCK = 1'b0;
  logic            RESET = 1'b1;
  logic            enable_sensor_mode = 1'b1;
  logic [NS-1:0]   sensor = '0;
  logic [2:0]      main_light;
  logic [3*NS-1:0] side_light;
  logic            walk_active;
  logic [3:0]      walk_digit;
  logic [NS-1:0]   pending;
  logic [2:0]      phase;

  sensor_mode_ctrl #(
    .N_SIDE(NS), .TICK_DIV(4), .MIN_GREEN(3), .SIDE_GREEN(4),
    .YELLOW(2), .ALL_RED(1), .WALK_TIME(3)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET), .enable_sensor_mode(enable_sensor_mode),
    .sensor(sensor), .main_light(main_light), .side_light(side_light),
    .walk_active(walk_active), .walk_digit(walk_digit),
    .pending(pending), .phase(phase)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [19:0] vec;
    int          dur;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         ev;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc;
  int          last_cyc = 0;
  logic [19:0] prev_vec = RST_VEC;
  logic [19:0] cur_vec;

  assign cur_vec = {phase, main_light, side_light, walk_active, walk_digit};

  // Cycle count since the last reset release
  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] side_vec(input int k, input logic [2:0] c);
    logic [8:0] v;
    v = ALL_R;
    v[3*k +: 3] = c;
    return v;
  endfunction

  task automatic push_ev(input logic [2:0] ph, input logic [2:0] ml, input logic [8:0] sl,
                         input logic wa, input logic [3:0] wd, input int dur);
    ev_t e;
    e.vec = {ph, ml, sl, wa, wd};
    e.dur = dur;
    exp_q.push_back(e);
  endtask

  // One full side service of approach k; extra stretches the walk=2 interval
  task automatic push_side_cycle(input int k, input int main_dur, input int extra);
    push_ev(3'd1, Y, ALL_R, 1'b0, 4'd0, main_dur);
    push_ev(3'd2, R, ALL_R, 1'b0, 4'd0, 8);
    push_ev(3'd3, R, side_vec(k, G), 1'b1, 4'd3, 4);
    push_ev(3'd3, R, side_vec(k, G), 1'b1, 4'd2, 4);
    push_ev(3'd3, R, side_vec(k, G), 1'b1, 4'd1, 4 + extra);
    push_ev(3'd3, R, side_vec(k, G), 1'b1, 4'd0, 4);
    push_ev(3'd4, R, side_vec(k, Y), 1'b0, 4'd0, 4);
    push_ev(3'd5, R, ALL_R, 1'b0, 4'd0, 8);
    push_ev(3'd0, G, ALL_R, 1'b0, 4'd0, 4);
  endtask

  // Monitor: every output change must match the next queued expectation
  always @(negedge CLOCK) begin
    if (RESET) begin
      prev_vec = RST_VEC;
      last_cyc = 0;
    end else if (cur_vec !== prev_vec) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output_change: got 0x%0h, expected no change from 0x%0h (t=%0t)",
                 cur_vec, prev_vec, $time);
      end else begin
        ev = exp_q.pop_front();
        check("event_outputs", cur_vec, ev.vec);
        check("event_spacing_cycles", cyc - last_cyc, ev.dur);
      end
      prev_vec = cur_vec;
      last_cyc = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    sensor = '0;
    enable_sensor_mode = 1'b1;
    step(2);
    check("reset_outputs", cur_vec, RST_VEC);
    check("reset_pending", pending, 0);
    RESET = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      step(1);
      i++;
    end
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    // Idle: no requests, main green holds for 200 cycles
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      step(1);
      check("idle_outputs", cur_vec, RST_VEC);
    end
    check("idle_pending", pending, 0);

    // Single request on approach 1
    apply_reset();
    push_side_cycle(1, 12, 0);
    step(1);
    sensor = 3'b010;
    step(1);
    sensor = 3'b000;
    check("single_pending_set", pending, 3'b010);
    step(21);
    check("single_pending_before_green", pending, 3'b010);
    step(1);
    check("single_pending_cleared", pending, 3'b000);
    step(32);

    // Round-robin: 0 and 2 together after serving 1 -> 2 first, then 0
    push_side_cycle(2, 12, 0);
    push_side_cycle(0, 12, 0);
    step(1);
    sensor = 3'b101;
    step(1);
    sensor = 3'b000;
    check("rr_pending_set", pending, 3'b101);
    step(22);
    check("rr_pending_after_first", pending, 3'b001);
    wait_drain(200);

    // Freeze for 20 cycles in side green; sensor pulse during freeze ignored
    apply_reset();
    push_side_cycle(0, 12, 20);
    sensor = 3'b001;
    step(1);
    sensor = 3'b000;
    check("freeze_pending_set", pending, 3'b001);
    step(29);
    enable_sensor_mode = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1);
      if (i == 4) sensor = 3'b010;
      if (i == 5) sensor = 3'b000;
      check("freeze_outputs", cur_vec, {3'd3, R, side_vec(0, G), 1'b1, 4'd2});
      check("freeze_pending", pending, 3'b000);
    end
    enable_sensor_mode = 1'b1;
    step(1);
    check("freeze_pending_after", pending, 3'b000);
    wait_drain(200);
    step(40);
    check("freeze_no_service", phase, 3'd0);

    // Asynchronous reset during main yellow with two requests latched
    apply_reset();
    push_ev(3'd1, Y, ALL_R, 1'b0, 4'd0, 12);
    sensor = 3'b101;
    step(1);
    sensor = 3'b000;
    check("abort_pending_set", pending, 3'b101);
    step(13);
    check("abort_in_yellow", phase, 3'd1);
    check("abort_queue_empty", exp_q.size(), 0);
    RESET = 1'b1;
    #1;
    check("abort_async_outputs", cur_vec, RST_VEC);
    check("abort_async_pending", pending, 0);
    step(1);
    RESET = 1'b0;
    push_side_cycle(2, 12, 0);
    sensor = 3'b100;
    step(1);
    sensor = 3'b000;
    wait_drain(100);

    // Set/clear collision: sensor 0 held across its own green entry
    apply_reset();
    push_side_cycle(0, 12, 0);
    push_side_cycle(0, 12, 0);
    sensor = 3'b001;
    step(1);
    check("collide_pending_set", pending, 3'b001);
    step(23);
    check("collide_pending_kept", pending, 3'b001);
    step(2);
    sensor = 3'b000;
    step(54);
    check("collide_pending_second_clear", pending, 3'b000);
    wait_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sensor_mode_ctrl.md
# sensor_mode_ctrl

Parametrised, sensor-actuated night-mode traffic controller for one main street and N_SIDE side approaches, with a pedestrian walk countdown. Main street rests on green. Latched side-street sensor requests are served round-robin, each through a fixed yellow/all-red/green/yellow/all-red sequence timed by an internal second-tick prescaler. It sits under the mode selector alongside the day-mode controller. Its light and countdown outputs feed the existing light drivers and the walk-display decoder.

## Interface

Parameters:
- N_SIDE, 2: number of side approaches (1..8)
- TICK_DIV, 50_000_000: CLOCK cycles per one-second tick (≥2)
- MIN_GREEN, 10: minimum main green, ticks (≥1)
- SIDE_GREEN, 8: side green, ticks (≥1)
- YELLOW, 3: yellow duration, ticks (≥1)
- ALL_RED, 1: all-red clearance, ticks (≥1)
- WALK_TIME, 9: walk countdown start value (0..9, ≤ SIDE_GREEN)

Ports:
- CLOCK  in  1  system clock, rising edge
- RESET  in  1  asynchronous, active-high; one clock, no other clock domains
- enable_sensor_mode  in  1  high = block runs; low = full freeze
- sensor  in  N_SIDE  debounced per-approach vehicle-present levels
- main_light  out  3  one-hot {R,Y,G}
- side_light  out  3*N_SIDE  one-hot {R,Y,G} per approach; approach k in bits [3k+2:3k]
- walk_active  out  1  high during SIDE_GREEN
- walk_digit  out  4  countdown value 0..9 for the walk decoder
- pending  out  N_SIDE  latched requests
- phase  out  3  current state code

## Operation

- States/codes: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_A=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_B=5. Codes 6–7 are unreachable and recover to MAIN_GREEN.
- Timer: loaded with (duration−1) on state entry. Decrements on tick. The state ends on a tick with timer==0.
- Each state lasts exactly duration×TICK_DIV cycles, because the prescaler clears on every state change.
- MAIN_GREEN:
  - min_done sets on the tick where timer==0.
  - Exit to MAIN_YELLOW on any cycle with min_done=1 and pending≠0.
  - Otherwise hold indefinitely.
- On MAIN_GREEN exit, latch served = first pending index searching from (last_served+1) mod N_SIDE upward with wrap.
- Transitions: MAIN_YELLOW→ALL_RED_A→SIDE_GREEN→SIDE_YELLOW→ALL_RED_B→MAIN_GREEN, each on its timer expiry. last_served←served on entry to ALL_RED_B.
- Lights:
  - main is G/Y in MAIN_GREEN/MAIN_YELLOW, else R.
  - side[served] is G/Y in SIDE_GREEN/SIDE_YELLOW.
  - All other approaches are always R.
  - No two approaches are ever non-red together.
- Requests:
  - pending[k] sets when sensor[k]=1 and enabled.
  - pending[served] clears on SIDE_GREEN entry.
  - Simultaneous set and clear: set wins.
- Walk:
  - On SIDE_GREEN entry, walk_digit=WALK_TIME, walk_active=1.
  - walk_digit decrements per tick, saturating at 0.
  - Outside SIDE_GREEN, walk_digit=0 and walk_active=0.
- enable_sensor_mode=0: prescaler, timer, state, pending, and all outputs hold. Sensors are ignored.
- Reset values:
  - State, light, and walk outputs: phase=0, main_light=G, all side_light=R, walk_active=0, walk_digit=0.
  - Control registers: pending=0, min_done=0, timer=MIN_GREEN−1, prescaler=0, last_served=N_SIDE−1 (first service goes to approach 0).

## Timing

- All outputs are registered and change on the CLOCK edge after the deciding condition.
- Sensor high at edge t → pending at t+1. If min_done=1, phase=1 at t+2.
- RESET acts immediately (asynchronous). Outputs hold reset values until the first edge after deassertion.
- RESET mid-sequence aborts to MAIN_GREEN with a fresh minimum green. No yellow is inserted.
- Worst-case request wait: (N_SIDE−1) full side cycles plus MIN_GREEN.

## Test plan

All scenarios use N_SIDE=3, TICK_DIV=4, MIN_GREEN=3, YELLOW=2, ALL_RED=1, SIDE_GREEN=4, WALK_TIME=3, with enable high unless stated.

1. Idle: release RESET, no sensors, run 200 cycles → phase=0, main_light=G, all sides R, walk_active=0 throughout.
2. Single request: sensor[1] one-cycle pulse 2 cycles after reset.
   - pending[1]=1 next cycle; phase=1 at cycle 12, held 8 cycles; then phase=2 for 4 cycles.
   - Then side1=G for 16 cycles, walk_digit 3,2,1,0 for 4 cycles each; pending[1]=0 at green entry.
   - Then yellow 8, all-red 4, then phase=0.
3. Round-robin: after serving approach 1, pulse sensor[0] and sensor[2] together → approach 2 served first, then after a full MIN_GREEN, approach 0.
4. Freeze: drop enable for 20 cycles mid SIDE_GREEN → every output constant; SIDE_GREEN total length 36 cycles; sensor pulses during freeze are not latched.
5. Reset mid-operation: assert RESET during MAIN_YELLOW with pending=3'b101 → same cycle main_light=G, pending=0, phase=0.
6. Set/clear collision: hold sensor[0] high across SIDE_GREEN entry for approach 0 → pending[0] stays 1; approach 0 is served again after the next MIN_GREEN.
